// File: rtl/reg_port_arbiter_if.sv
// Request/grant/read-data signal bundle between two register-read requesters,
// the shared register-file read port and the reg_port_arbiter.
interface reg_port_arbiter_if #(
  parameter int unsigned DATA_W = 64
);
  logic              ReqA;
  logic [4:0]        AddrA;
  logic              ReqB;
  logic [4:0]        AddrB;
  logic              GntA;
  logic              GntB;
  logic              Sel;
  logic [4:0]        RdAddr;
  logic [DATA_W-1:0] RdData;
  logic [DATA_W-1:0] DataA;
  logic              ValidA;
  logic [DATA_W-1:0] DataB;
  logic              ValidB;
  logic              Busy;

  // Arbiter side
  modport slave (
    input  ReqA, AddrA, ReqB, AddrB, RdData,
    output GntA, GntB, Sel, RdAddr, DataA, ValidA, DataB, ValidB, Busy
  );

  // Requester / register-file side
  modport master (
    output ReqA, AddrA, ReqB, AddrB, RdData,
    input  GntA, GntB, Sel, RdAddr, DataA, ValidA, DataB, ValidB, Busy
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one combinational register-file read port
// between two requesters; grant one cycle after request, data one cycle after grant.
module reg_port_arbiter #(
  parameter int unsigned DATA_W = 64
) (
  input logic                 CLK,
  input logic                 RESET_N,
  reg_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic              last_b_q, last_b_d;
  logic [4:0]        addr_q,   addr_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic              valid_a_q, valid_a_d;
  logic              valid_b_q, valid_b_d;

  logic win_a;
  logic win_b;

  // On a tie the requester not served most recently wins.
  always_comb begin
    win_a = bus.ReqA & (~bus.ReqB |  last_b_q);
    win_b = bus.ReqB & (~bus.ReqA | ~last_b_q);
  end

  always_comb begin
    state_d   = IDLE;
    last_b_d  = last_b_q;
    addr_d    = addr_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;

    if (win_a) begin
      state_d  = SERVE_A;
      last_b_d = 1'b0;
      addr_d   = bus.AddrA;
    end else if (win_b) begin
      state_d  = SERVE_B;
      last_b_d = 1'b1;
      addr_d   = bus.AddrB;
    end

    // The grant cycle ends on this edge: capture what the read port returned.
    case (state_q)
      SERVE_A: begin
        data_a_d  = bus.RdData;
        valid_a_d = 1'b1;
      end
      SERVE_B: begin
        data_b_d  = bus.RdData;
        valid_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      addr_q    <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      addr_q    <= addr_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  assign bus.GntA   = (state_q == SERVE_A);
  assign bus.GntB   = (state_q == SERVE_B);
  assign bus.Sel    = (state_q == SERVE_B);
  assign bus.Busy   = (state_q == SERVE_A) | (state_q == SERVE_B);
  assign bus.RdAddr = addr_q;
  assign bus.DataA  = data_a_q;
  assign bus.ValidA = valid_a_q;
  assign bus.DataB  = data_b_q;
  assign bus.ValidB = valid_b_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Self-checking bench for reg_port_arbiter: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a behavioural model.
module tb_reg_port_arbiter;

  localparam int unsigned DW = 64;

  logic clk;
  logic rst_n;
  logic [DW-1:0] rf [32];

  int unsigned checks;
  int unsigned errors;

  reg_port_arbiter_if #(.DATA_W(DW)) bus ();

  reg_port_arbiter #(.DATA_W(DW)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  assign bus.RdData = rf[bus.RdAddr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ra;
    logic [4:0]  aa;
    logic        rb;
    logic [4:0]  ab;
    logic        ga;
    logic        gb;
    logic [4:0]  addr;
    logic        va;
    logic        vb;
    logic [63:0] da;
    logic [63:0] db;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [63:0] rfval(input int unsigned i);
    if (i == 3) return 64'h1234;
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0101);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic ga, input logic gb,
                          input logic [4:0] addr, input logic va, input logic vb,
                          input logic [63:0] da, input logic [63:0] db);
    chk({nm, "_gnta"},   64'(bus.GntA),   64'(ga));
    chk({nm, "_gntb"},   64'(bus.GntB),   64'(gb));
    chk({nm, "_sel"},    64'(bus.Sel),    64'(gb));
    chk({nm, "_busy"},   64'(bus.Busy),   64'(ga | gb));
    chk({nm, "_rdaddr"}, 64'(bus.RdAddr), 64'(addr));
    chk({nm, "_valida"}, 64'(bus.ValidA), 64'(va));
    chk({nm, "_validb"}, 64'(bus.ValidB), 64'(vb));
    chk({nm, "_dataa"},  bus.DataA,       da);
    chk({nm, "_datab"},  bus.DataB,       db);
  endtask

  task automatic drive(input logic ra, input logic [4:0] aa, input logic rb, input logic [4:0] ab);
    bus.ReqA  = ra;
    bus.AddrA = aa;
    bus.ReqB  = rb;
    bus.AddrB = ab;
  endtask

  // Enters and leaves on a falling edge; reset spans one rising edge.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural model state for the random phase
  logic        m_last_b;
  int unsigned m_gnt;     // 0 none, 1 A, 2 B
  logic [4:0]  m_addr;
  logic [63:0] m_da, m_db;
  logic        m_va, m_vb;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = rfval(i);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    tbl[0] = '{1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 64'd0,     64'd0};
    tbl[1] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 64'h1234,  64'd0};
    tbl[2] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  1'b0, 1'b0, 64'h1234,  64'd0};
    tbl[3] = '{1'b1, 5'd5,  1'b1, 5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 64'h1234,  64'd0};
    tbl[4] = '{1'b1, 5'd5,  1'b1, 5'd9,  1'b1, 1'b0, 5'd5,  1'b0, 1'b1, 64'h1234,  rfval(9)};
    tbl[5] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, rfval(5),  rfval(9)};
    tbl[6] = '{1'b0, 5'd0,  1'b1, 5'd31, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, rfval(5),  rfval(9)};
    tbl[7] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd31, 1'b0, 1'b1, rfval(5),  rfval(31)};
    tbl[8] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, rfval(5),  rfval(31)};
    tbl[9] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, rfval(0),  rfval(31)};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ra, tbl[i].aa, tbl[i].rb, tbl[i].ab);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].addr,
               tbl[i].va, tbl[i].vb, tbl[i].da, tbl[i].db);
    end

    // ---------------- first tie after reset ----------------
    do_reset();
    drive(1'b1, 5'd5, 1'b1, 5'd9);
    @(negedge clk);
    chk_outs("tie0", 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b0, 5'd5, 1'b1, 5'd9);
    @(negedge clk);
    chk_outs("tie1", 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, rfval(5), 64'd0);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk_outs("tie2", 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, rfval(5), rfval(9));

    // ---------------- sustained contention ----------------
    do_reset();
    drive(1'b1, 5'd7, 1'b1, 5'd12);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_gnta", k), 64'(bus.GntA), 64'((k % 2) == 0));
      chk($sformatf("cont%0d_gntb", k), 64'(bus.GntB), 64'((k % 2) == 1));
      chk($sformatf("cont%0d_busy", k), 64'(bus.Busy), 64'd1);
      chk($sformatf("cont%0d_vb", k),   64'(bus.ValidB), 64'(k > 0 && (k % 2) == 0));
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("cont_end_busy", 64'(bus.Busy),   64'd0);
    chk("cont_end_vb",   64'(bus.ValidB), 64'd1);
    chk("cont_end_db",   bus.DataB,       rfval(12));

    // ---------------- lone streamer B ----------------
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(20 + k));
      @(negedge clk);
      chk($sformatf("strm%0d_gntb", k), 64'(bus.GntB),   64'd1);
      chk($sformatf("strm%0d_addr", k), 64'(bus.RdAddr), 64'(20 + k));
      chk($sformatf("strm%0d_vb", k),   64'(bus.ValidB), 64'(k > 0));
      if (k > 0) chk($sformatf("strm%0d_db", k), bus.DataB, rfval(20 + k - 1));
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("strm4_gntb", 64'(bus.GntB),   64'd0);
    chk("strm4_vb",   64'(bus.ValidB), 64'd1);
    chk("strm4_db",   bus.DataB,       rfval(23));
    @(negedge clk);
    chk("strm5_vb",   64'(bus.ValidB), 64'd0);

    // ---------------- reset in the middle of a B grant ----------------
    drive(1'b0, 5'd0, 1'b1, 5'd2);
    @(negedge clk);
    chk("mid_gntb", 64'(bus.GntB), 64'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_vb", 64'(bus.ValidB), 64'd0);
    chk("mid_after_db", bus.DataB,       64'd0);
    drive(1'b1, 5'd4, 1'b1, 5'd6);
    @(negedge clk);
    chk_outs("mid_tie", 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b0, 5'd0, 1'b0, 5'd0);

    // ---------------- randomized traffic vs. model ----------------
    do_reset();
    m_last_b = 1'b1;
    m_gnt    = 0;
    m_addr   = 5'd0;
    m_da     = '0;
    m_db     = '0;
    m_va     = 1'b0;
    m_vb     = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic        ra, rb;
      logic [4:0]  aa, ab;
      int unsigned w;
      rf[$urandom_range(0, 31)] = {$urandom, $urandom};
      ra = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) != 0);
      aa = 5'($urandom_range(0, 31));
      ab = 5'($urandom_range(0, 31));
      drive(ra, aa, rb, ab);

      // Whoever holds the port now receives its data after this edge.
      m_va = (m_gnt == 1);
      m_vb = (m_gnt == 2);
      if (m_va) m_da = rf[m_addr];
      if (m_vb) m_db = rf[m_addr];
      if (ra && rb)  w = m_last_b ? 1 : 2;
      else if (ra)   w = 1;
      else if (rb)   w = 2;
      else           w = 0;
      if (w == 1) begin m_addr = aa; m_last_b = 1'b0; end
      if (w == 2) begin m_addr = ab; m_last_b = 1'b1; end
      m_gnt = w;

      @(negedge clk);
      chk_outs("rand", (m_gnt == 1), (m_gnt == 2), m_addr, m_va, m_vb, m_da, m_db);
      chk("rand_mutex_gnt",   64'(bus.GntA & bus.GntB),     64'd0);
      chk("rand_mutex_valid", 64'(bus.ValidA & bus.ValidB), 64'd0);
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
